// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI-style burst read port between the icache and dcache refill
// engines. A whole burst (address phase through last beat) is granted to one
// requester at a time, with round-robin on simultaneous requests. Read data is
// passed straight through to the owner; beat count and returned ID are checked
// and any inconsistency raises a sticky error flag.
module cache_axi_rd_arbiter #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // icache refill master
  input  logic [31:0]           i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic                  i_arvalid,
  output logic                  i_arready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rlast,
  output logic                  i_rvalid,
  input  logic                  i_rready,

  // dcache refill master
  input  logic [31:0]           d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic [2:0]            d_arsize,
  input  logic                  d_arvalid,
  output logic                  d_arready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rlast,
  output logic                  d_rvalid,
  input  logic                  d_rready,

  // shared SoC read channel
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [31:0]           m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,

  output logic                  busy,
  output logic                  beat_err
);

  // Requester encoding doubles as the AXI ID: icache tagged 0, dcache tagged 1.
  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                beat_err_q, beat_err_d;

  logic [ID_WIDTH-1:0] owner_id;
  logic                ar_hs;
  logic                r_hs;
  logic                beat_bad;

  assign owner_id = ID_WIDTH'(owner_q);

  // Handshakes only count in the phase that owns them.
  assign ar_hs = (state_q == StAr) && m_arvalid && m_arready;
  assign r_hs  = (state_q == StR) && m_rvalid && m_rready;

  // A beat is bad if rlast disagrees with the expected final beat, or the ID
  // does not belong to the current owner.
  assign beat_bad = (m_rlast != (beat_cnt_q == len_q)) || (m_rid != owner_id);

  assign busy     = (state_q != StIdle);
  assign beat_err = beat_err_q;

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnerI;
      last_grant_q <= OwnerI;
      len_q        <= 8'd0;
      beat_cnt_q   <= 8'd0;
      beat_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_err_q   <= beat_err_d;
    end
  end

  // Next-state: arbitration in idle, address acceptance, beat tracking.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    beat_err_d   = beat_err_q;

    unique case (state_q)
      StIdle: begin
        if (i_arvalid || d_arvalid) begin
          // On a tie the requester that did not win last time goes first.
          if (i_arvalid && d_arvalid) begin
            owner_d = ~last_grant_q;
          end else if (d_arvalid) begin
            owner_d = OwnerD;
          end else begin
            owner_d = OwnerI;
          end
          last_grant_d = owner_d;
          state_d      = StAr;
        end
      end

      StAr: begin
        // Owner is committed until its burst completes, even if arvalid drops.
        if (ar_hs) begin
          len_d      = (owner_q == OwnerD) ? d_arlen : i_arlen;
          beat_cnt_d = 8'd0;
          state_d    = StR;
        end
      end

      StR: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_bad) begin
            beat_err_d = 1'b1;
          end
          if (m_rlast) begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output steering: address from the owner in AR, data to the owner in R.
  always_comb begin
    m_arid    = '0;
    m_araddr  = 32'd0;
    m_arlen   = 8'd0;
    m_arsize  = 3'd0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rdata   = '0;
    i_rlast   = 1'b0;
    i_rvalid  = 1'b0;
    d_rdata   = '0;
    d_rlast   = 1'b0;
    d_rvalid  = 1'b0;

    unique case (state_q)
      StAr: begin
        m_arid = owner_id;
        if (owner_q == OwnerD) begin
          m_araddr  = d_araddr;
          m_arlen   = d_arlen;
          m_arsize  = d_arsize;
          m_arvalid = d_arvalid;
          d_arready = m_arready;
        end else begin
          m_araddr  = i_araddr;
          m_arlen   = i_arlen;
          m_arsize  = i_arsize;
          m_arvalid = i_arvalid;
          i_arready = m_arready;
        end
      end

      StR: begin
        if (owner_q == OwnerD) begin
          d_rdata  = m_rdata;
          d_rlast  = m_rlast;
          d_rvalid = m_rvalid;
          m_rready = d_rready;
        end else begin
          i_rdata  = m_rdata;
          i_rlast  = m_rlast;
          i_rvalid = m_rvalid;
          m_rready = i_rready;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: doc/cache_axi_rd_arbiter.md
Name: cache_axi_rd_arbiter

Overview:
- Shares one AXI-style burst read port between the instruction cache and the data cache refill engines.
- Grants one whole burst at a time: address phase through last beat. Uses round-robin when both caches request together.
- Routes read data back to the owner and checks beat count and ID consistency.
- Sits between the i_cache/d_cache refill masters and the SoC AXI read channel.

Parameters:
- ID_WIDTH, 4, width of arid/rid. The icache is tagged 0 and the dcache is tagged 1.
- DATA_WIDTH, 32, width of read data.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_araddr  in  32  icache burst address
- i_arlen  in  8  icache burst length minus 1
- i_arsize  in  3  icache beat size
- i_arvalid  in  1  icache address valid
- i_arready  out  1  icache address accepted
- i_rdata  out  DATA_WIDTH  icache read data
- i_rlast  out  1  icache last beat
- i_rvalid  out  1  icache data valid
- i_rready  in  1  icache data ready
- d_araddr, d_arlen, d_arsize, d_arvalid, d_arready, d_rdata, d_rlast, d_rvalid, d_rready: same widths and directions as the i_ set, for the dcache
- m_arid  out  ID_WIDTH  ID of the granted requester
- m_araddr  out  32  forwarded address
- m_arlen  out  8  forwarded length
- m_arsize  out  3  forwarded size
- m_arvalid  out  1  address valid to the bus
- m_arready  in  1  bus address accepted
- m_rid  in  ID_WIDTH  returned ID
- m_rdata  in  DATA_WIDTH  returned data
- m_rlast  in  1  returned last beat
- m_rvalid  in  1  returned data valid
- m_rready  out  1  data ready to the bus
- busy  out  1  high when the state is not IDLE
- beat_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=I, last_grant=I, beat_cnt=0, beat_err=0.
  - All m_* outputs and all *_ready/*_valid outputs are 0; m_arid=0.
- States: IDLE, AR, R.
- IDLE:
  - If exactly one of i_arvalid/d_arvalid is high, grant that requester.
  - If both are high, grant the opposite of last_grant. Because last_grant resets to I, the dcache wins the first tie.
  - On a grant: owner<=winner, last_grant<=winner, go to AR. All m_* outputs stay 0 while in IDLE.
- AR:
  - m_araddr/arlen/arsize/arvalid are driven combinationally from the owner's inputs.
  - m_arid is 0 for I and 1 for D.
  - The owner's arready equals m_arready; the non-owner's arready is 0.
  - On m_arvalid & m_arready: latch len<=owner arlen, beat_cnt<=0, go to R.
  - If the owner drops arvalid, remain in AR with m_arvalid=0. No re-arbitration.
- R:
  - Owner's rdata/rlast/rvalid = m_rdata/m_rlast/m_rvalid.
  - m_rready = owner rready.
  - Non-owner rvalid=0 and rlast=0; its rdata is don't-care.
  - Each beat handshake (m_rvalid & m_rready) increments beat_cnt.
  - A handshake with m_rlast=1 returns the state to IDLE.
- Latency:
  - arvalid seen in IDLE at cycle t gives m_arvalid at t+1.
  - A final beat at cycle t gives IDLE at t+1; the next grant's m_arvalid follows at t+2.
- beat_err is set on a beat handshake in any of these cases:
  - m_rlast=1 with beat_cnt != len.
  - beat_cnt == len with m_rlast=0.
  - m_rid != owner ID.
  - Once set, beat_err stays high until reset. An error does not change the state-machine flow.
- No data is buffered; rvalid/rready pass straight through, so there is no added data latency.
- A request raised by the non-owner during AR or R waits. It is granted in IDLE after the current burst finishes.

Test Plan:
- Reset with both valids high -> all outputs 0, busy=0. After rst rises, the dcache is granted: m_arid=1 and m_araddr=d_araddr at the next cycle.
- Only icache requests: araddr=0x1FC0_0000, arlen=7. Bus returns 8 beats 0xA0..0xA7 with rlast on the 8th -> i_rvalid pulses 8 times with that data, d_rvalid stays 0, IDLE the cycle after the last beat, beat_err=0.
- Both request continuously for 4 bursts -> grants alternate D, I, D, I, with m_arid 1, 0, 1, 0.
- m_arready held low for 5 cycles -> m_arvalid stays high and the address is stable. i_arready pulses only in the accept cycle.
- Bus asserts rlast on beat 3 of an arlen=7 burst -> beat_err=1 and IDLE the next cycle. beat_err stays 1 through later good bursts.
- rst pulled low mid-burst after beat 2 -> outputs 0 immediately. After release, the state is IDLE and a pending request is granted again.
